// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with an architectural flag register and a saturating overflow counter.
// Optional sticky overflow trap is enabled by defining EXMEM_OVF_TRAP_EN.
module exmem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic        ex_z,
  input  logic        ex_ovf,
  input  logic [2:0]  ex_rd,
  input  logic        ex_wr_en,
  input  logic        ex_flag_upd,
  output logic        ex_ready,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic [15:0] mem_alu_out,
  output logic [2:0]  mem_rd,
  output logic        mem_wr_en,
  output logic        flag_z,
  output logic        flag_ovf,
  output logic [7:0]  ovf_cnt,
  output logic        ovf_trap,
  input  logic        trap_clr
);

  logic        mem_valid_q, mem_valid_d;
  logic [15:0] mem_alu_out_q, mem_alu_out_d;
  logic [2:0]  mem_rd_q, mem_rd_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_ovf_q, flag_ovf_d;
  logic [7:0]  ovf_cnt_q, ovf_cnt_d;
  logic        accept;
  logic        flag_wr;
  logic        ovf_event;

  // Ready depends only on the held entry so upstream can compute valid independently.
  assign ex_ready  = !mem_valid_q || !mem_stall;
  assign accept    = ex_valid && ex_ready && !flush;
  assign flag_wr   = accept && ex_flag_upd;
  assign ovf_event = flag_wr && ex_ovf;

  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_alu_out_d = mem_alu_out_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_en_d   = mem_wr_en_q;
    if (flush) begin
      mem_valid_d = 1'b0;
      mem_wr_en_d = 1'b0;
    end else if (accept) begin
      mem_valid_d   = 1'b1;
      mem_alu_out_d = ex_alu_out;
      mem_rd_d      = ex_rd;
      mem_wr_en_d   = ex_wr_en;
    end else if (mem_valid_q && !mem_stall) begin
      mem_valid_d = 1'b0;
    end
  end

  always_comb begin
    flag_z_d   = flag_z_q;
    flag_ovf_d = flag_ovf_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (flag_wr) begin
      flag_z_d   = ex_z;
      flag_ovf_d = ex_ovf;
    end
    if (ovf_event && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_q   <= 1'b0;
      mem_alu_out_q <= 16'h0000;
      mem_rd_q      <= 3'b000;
      mem_wr_en_q   <= 1'b0;
      flag_z_q      <= 1'b0;
      flag_ovf_q    <= 1'b0;
      ovf_cnt_q     <= 8'h00;
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_alu_out_q <= mem_alu_out_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_en_q   <= mem_wr_en_d;
      flag_z_q      <= flag_z_d;
      flag_ovf_q    <= flag_ovf_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

`ifdef EXMEM_OVF_TRAP_EN
  logic ovf_trap_q, ovf_trap_d;

  // Set wins over clear so an overflow coinciding with trap_clr is never lost.
  always_comb begin
    ovf_trap_d = ovf_trap_q;
    if (ovf_event) begin
      ovf_trap_d = 1'b1;
    end else if (trap_clr) begin
      ovf_trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_trap_q <= 1'b0;
    end else begin
      ovf_trap_q <= ovf_trap_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign ovf_trap        = 1'b0;
`endif

  assign mem_valid   = mem_valid_q;
  assign mem_alu_out = mem_alu_out_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign flag_z      = flag_z_q;
  assign flag_ovf    = flag_ovf_q;
  assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage; expectations are hand-computed constants.
// Trap expectations follow EXMEM_OVF_TRAP_EN when it is defined for the build.
module tb_exmem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic        ex_z;
  logic        ex_ovf;
  logic [2:0]  ex_rd;
  logic        ex_wr_en;
  logic        ex_flag_upd;
  logic        ex_ready;
  logic        mem_stall;
  logic        flush;
  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic [2:0]  mem_rd;
  logic        mem_wr_en;
  logic        flag_z;
  logic        flag_ovf;
  logic [7:0]  ovf_cnt;
  logic        ovf_trap;
  logic        trap_clr;

  int checks;
  int errors;

  exmem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_z        (ex_z),
    .ex_ovf      (ex_ovf),
    .ex_rd       (ex_rd),
    .ex_wr_en    (ex_wr_en),
    .ex_flag_upd (ex_flag_upd),
    .ex_ready    (ex_ready),
    .mem_stall   (mem_stall),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_alu_out (mem_alu_out),
    .mem_rd      (mem_rd),
    .mem_wr_en   (mem_wr_en),
    .flag_z      (flag_z),
    .flag_ovf    (flag_ovf),
    .ovf_cnt     (ovf_cnt),
    .ovf_trap    (ovf_trap),
    .trap_clr    (trap_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".mem_valid"},   {31'd0, mem_valid},   32'd0);
    check({tag, ".mem_alu_out"}, {16'd0, mem_alu_out}, 32'h0000);
    check({tag, ".mem_rd"},      {29'd0, mem_rd},      32'd0);
    check({tag, ".mem_wr_en"},   {31'd0, mem_wr_en},   32'd0);
    check({tag, ".flag_z"},      {31'd0, flag_z},      32'd0);
    check({tag, ".flag_ovf"},    {31'd0, flag_ovf},    32'd0);
    check({tag, ".ovf_cnt"},     {24'd0, ovf_cnt},     32'd0);
    check({tag, ".ovf_trap"},    {31'd0, ovf_trap},    32'd0);
    check({tag, ".ex_ready"},    {31'd0, ex_ready},    32'd1);
  endtask

  logic trap_en;

  initial begin
    checks = 0;
    errors = 0;
`ifdef EXMEM_OVF_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_out = 16'h0; ex_z = 1'b0; ex_ovf = 1'b0;
    ex_rd = 3'd0; ex_wr_en = 1'b0; ex_flag_upd = 1'b0;
    mem_stall = 1'b0; flush = 1'b0; trap_clr = 1'b0;
    #1;
    check_reset_vals("rst_init");
    tick();
    tick();
    rst = 1'b0;

    // Basic single-cycle transfer
    ex_valid = 1'b1; ex_alu_out = 16'h1234; ex_rd = 3'd5; ex_wr_en = 1'b1;
    tick();
    check("xfer.valid", {31'd0, mem_valid},   32'd1);
    check("xfer.alu",   {16'd0, mem_alu_out}, 32'h1234);
    check("xfer.rd",    {29'd0, mem_rd},      32'd5);
    check("xfer.wr_en", {31'd0, mem_wr_en},   32'd1);

    // Stall for 3 cycles with new data waiting
    ex_alu_out = 16'hBEEF; ex_rd = 3'd3; mem_stall = 1'b1;
    #1;
    check("stall.ready", {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.hold_alu",   {16'd0, mem_alu_out}, 32'h1234);
      check("stall.hold_valid", {31'd0, mem_valid},   32'd1);
      check("stall.ready_lo",   {31'd0, ex_ready},    32'd0);
    end
    mem_stall = 1'b0;
    #1;
    check("release.ready", {31'd0, ex_ready}, 32'd1);
    tick();
    check("release.alu",   {16'd0, mem_alu_out}, 32'hBEEF);
    check("release.rd",    {29'd0, mem_rd},      32'd3);
    check("release.valid", {31'd0, mem_valid},   32'd1);
    ex_valid = 1'b0;
    tick();
    check("drain.valid", {31'd0, mem_valid},   32'd0);
    check("drain.alu",   {16'd0, mem_alu_out}, 32'hBEEF);

    // Flag-updating overflow op with zero result
    ex_valid = 1'b1; ex_alu_out = 16'h0000; ex_rd = 3'd1; ex_wr_en = 1'b1;
    ex_flag_upd = 1'b1; ex_z = 1'b1; ex_ovf = 1'b1;
    tick();
    check("flag.z",    {31'd0, flag_z},   32'd1);
    check("flag.ovf",  {31'd0, flag_ovf}, 32'd1);
    check("flag.cnt",  {24'd0, ovf_cnt},  32'd1);
    check("flag.trap", {31'd0, ovf_trap}, {31'd0, trap_en});

    // Non-updating op leaves flags alone
    ex_alu_out = 16'h7777; ex_flag_upd = 1'b0; ex_z = 1'b0; ex_ovf = 1'b0;
    tick();
    check("noupd.z",   {31'd0, flag_z},   32'd1);
    check("noupd.ovf", {31'd0, flag_ovf}, 32'd1);
    check("noupd.cnt", {24'd0, ovf_cnt},  32'd1);

    // Flush while stalled with a valid, overflowing op presented
    mem_stall = 1'b1; flush = 1'b1;
    ex_alu_out = 16'h4242; ex_flag_upd = 1'b1; ex_z = 1'b0; ex_ovf = 1'b1;
    tick();
    check("flush.valid", {31'd0, mem_valid}, 32'd0);
    check("flush.wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("flush.z",     {31'd0, flag_z},    32'd1);
    check("flush.ovf",   {31'd0, flag_ovf},  32'd1);
    check("flush.cnt",   {24'd0, ovf_cnt},   32'd1);
    flush = 1'b0; mem_stall = 1'b0; ex_valid = 1'b0;

    // Trap: clear, then set coinciding with clear, then clear
    trap_clr = 1'b1;
    tick();
    check("trap.clr0", {31'd0, ovf_trap}, 32'd0);
    ex_valid = 1'b1; ex_flag_upd = 1'b1; ex_ovf = 1'b1; ex_z = 1'b0;
    tick();
    check("trap.set_vs_clr", {31'd0, ovf_trap}, {31'd0, trap_en});
    check("trap.cnt",        {24'd0, ovf_cnt},  32'd2);
    check("trap.z",          {31'd0, flag_z},   32'd0);
    ex_valid = 1'b0;
    tick();
    check("trap.clr1", {31'd0, ovf_trap}, 32'd0);
    trap_clr = 1'b0;

    // Saturation: count is 2, 253 more ops reach 0xFF, further ops stay there
    ex_valid = 1'b1; ex_flag_upd = 1'b1; ex_ovf = 1'b1;
    for (int i = 0; i < 252; i++) tick();
    check("sat.fe", {24'd0, ovf_cnt}, 32'hFE);
    tick();
    check("sat.ff", {24'd0, ovf_cnt}, 32'hFF);
    for (int i = 0; i < 47; i++) tick();
    check("sat.hold", {24'd0, ovf_cnt}, 32'hFF);

    // Asynchronous reset mid-stall
    ex_alu_out = 16'h9999; ex_rd = 3'd6; ex_flag_upd = 1'b0; ex_ovf = 1'b0;
    tick();
    mem_stall = 1'b1; ex_alu_out = 16'hABCD; ex_rd = 3'd2;
    tick();
    check("pre_rst.alu", {16'd0, mem_alu_out}, 32'h9999);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    #1;
    rst = 1'b0;
    tick();
    check("post_rst.valid", {31'd0, mem_valid},   32'd1);
    check("post_rst.alu",   {16'd0, mem_alu_out}, 32'hABCD);
    check("post_rst.rd",    {29'd0, mem_rd},      32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
